decode_stage: RTL and testbench

//  Ps2->Ps3 decode stage of the RV32I core: the producer that feeds the Execute ALU.

---
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage.sv | 152 +++++++++++++++
 tb/tb_decode_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch instruction and regfile read in, Ps3 ALU operands and controls out.
// master = surrounding pipeline (fetch/regfile/execute), slave = decode_stage.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            valid_Ps2;
    logic            ready_Ps2;
    logic [31:0]     instr_Ps2;
    logic [XLEN-1:0] pc_Ps2;
    logic [4:0]      rs1_addr_Ps2;
    logic [4:0]      rs2_addr_Ps2;
    logic [XLEN-1:0] rs1_data_Ps2;
    logic [XLEN-1:0] rs2_data_Ps2;
    logic            stall_in;
    logic            flush;
    logic            valid_Ps3;
    logic [XLEN-1:0] Data_in1_Ps3;
    logic [XLEN-1:0] Data_in2_Ps3;
    logic [XLEN-1:0] Data_store_Ps3;
    logic [2:0]      Ctrl_ALU_Ps3;
    logic [6:0]      Ctrl_func7_Ps3;
    logic [4:0]      Ctrl_rd_Ps3;
    logic            Ctrl_rf_we_Ps3;
    logic            Ctrl_load_Ps3;
    logic            Ctrl_store_Ps3;
    logic            illegal_Ps3;

    modport master (
        output valid_Ps2, instr_Ps2, pc_Ps2, rs1_data_Ps2, rs2_data_Ps2, stall_in, flush,
        input  ready_Ps2, rs1_addr_Ps2, rs2_addr_Ps2, valid_Ps3, Data_in1_Ps3, Data_in2_Ps3,
               Data_store_Ps3, Ctrl_ALU_Ps3, Ctrl_func7_Ps3, Ctrl_rd_Ps3, Ctrl_rf_we_Ps3,
               Ctrl_load_Ps3, Ctrl_store_Ps3, illegal_Ps3
    );

    modport slave (
        input  valid_Ps2, instr_Ps2, pc_Ps2, rs1_data_Ps2, rs2_data_Ps2, stall_in, flush,
        output ready_Ps2, rs1_addr_Ps2, rs2_addr_Ps2, valid_Ps3, Data_in1_Ps3, Data_in2_Ps3,
               Data_store_Ps3, Ctrl_ALU_Ps3, Ctrl_func7_Ps3, Ctrl_rd_Ps3, Ctrl_rf_we_Ps3,
               Ctrl_load_Ps3, Ctrl_store_Ps3, illegal_Ps3
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I Ps2->Ps3 decode: regfile read, operand/control build, 1-cycle registered into Ps3.
// Backpressure: ready_Ps2 drops on stall_in or a load-use hazard (which inserts one bubble).
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rstn,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] st_dat;
        logic [2:0]      alu;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic            we;
        logic            load;
        logic            store;
        logic            illegal;
    } ps3_t;

    ps3_t        ps3_q;
    ps3_t        dec;
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        legal;
    logic        writes;
    logic        hazard;

    assign ins = bus.instr_Ps2;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];
    assign rd  = ins[11:7];

    assign bus.rs1_addr_Ps2 = ins[19:15];
    assign bus.rs2_addr_Ps2 = ins[24:20];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OPC_OP, OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OPIMM, OPC_LOAD: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        writes = 1'b0;
        case (opc)
            OPC_OP: begin
                dec.in1   = bus.rs1_data_Ps2;
                dec.in2   = bus.rs2_data_Ps2;
                dec.alu   = f3;
                dec.func7 = f7;
                writes    = 1'b1;
                legal     = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OPIMM: begin
                dec.in1 = bus.rs1_data_Ps2;
                dec.alu = f3;
                writes  = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.in2   = XLEN'(ins[24:20]);
                    dec.func7 = f7;
                    legal     = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
                end else begin
                    dec.in2 = {{(XLEN-12){ins[31]}}, ins[31:20]};
                end
            end
            OPC_LUI: begin
                dec.in2 = XLEN'({ins[31:12], 12'b0});
                writes  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.in1 = bus.pc_Ps2;
                dec.in2 = XLEN'({ins[31:12], 12'b0});
                writes  = 1'b1;
            end
            OPC_LOAD: begin
                dec.in1  = bus.rs1_data_Ps2;
                dec.in2  = {{(XLEN-12){ins[31]}}, ins[31:20]};
                dec.load = 1'b1;
                writes   = 1'b1;
            end
            OPC_STORE: begin
                dec.in1    = bus.rs1_data_Ps2;
                dec.in2    = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
                dec.st_dat = bus.rs2_data_Ps2;
                dec.store  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal instructions travel as live but side-effect-free so Execute can trap.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else begin
            dec.we = writes && (rd != 5'd0);
            dec.rd = writes ? rd : 5'd0;
        end
        dec.valid = 1'b1;
    end

    assign hazard = ps3_q.valid && ps3_q.load && (ps3_q.rd != 5'd0) &&
                    ((use_rs1 && ps3_q.rd == ins[19:15]) || (use_rs2 && ps3_q.rd == ins[24:20]));

    assign bus.ready_Ps2 = !bus.stall_in && !hazard;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ps3_q <= '0;
        end else if (bus.flush) begin
            ps3_q <= '0;
        end else if (bus.stall_in) begin
            ps3_q <= ps3_q;
        end else if (hazard || !bus.valid_Ps2) begin
            ps3_q <= '0;
        end else begin
            ps3_q <= dec;
        end
    end

    assign bus.valid_Ps3      = ps3_q.valid;
    assign bus.Data_in1_Ps3   = ps3_q.in1;
    assign bus.Data_in2_Ps3   = ps3_q.in2;
    assign bus.Data_store_Ps3 = ps3_q.st_dat;
    assign bus.Ctrl_ALU_Ps3   = ps3_q.alu;
    assign bus.Ctrl_func7_Ps3 = ps3_q.func7;
    assign bus.Ctrl_rd_Ps3    = ps3_q.rd;
    assign bus.Ctrl_rf_we_Ps3 = ps3_q.we;
    assign bus.Ctrl_load_Ps3  = ps3_q.load;
    assign bus.Ctrl_store_Ps3 = ps3_q.store;
    assign bus.illegal_Ps3    = ps3_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed RV32I vectors plus randomized traffic
// compared against an instruction-level reference model of the Ps3 register.
module tb_decode_stage;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] st;
        logic [2:0]  alu;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        sto;
        logic        ill;
    } exp_t;

    exp_t q;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, ex);
        end
    endtask

    function automatic bit rs1_used(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23);
    endfunction

    function automatic bit rs2_used(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h23);
    endfunction

    // What an RV32I decoder must hand to Execute for one instruction.
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic [2:0] f3   = ins[14:12];
        logic [6:0] f7   = ins[31:25];
        logic [4:0] rd   = ins[11:7];
        logic [11:0] simm = {ins[31:25], ins[11:7]};
        bit         ok   = 1'b1;
        bit         wr   = 1'b0;
        e = '0;
        case (ins[6:0])
            7'h33: begin
                e.in1 = a; e.in2 = b; e.alu = f3; e.f7 = f7; wr = 1'b1;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h13: begin
                e.in1 = a; e.alu = f3; wr = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.in2 = (ins >> 20) & 32'd31;
                    e.f7  = f7;
                    ok    = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                end else begin
                    e.in2 = 32'($signed(ins[31:20]));
                end
            end
            7'h37: begin e.in2 = ins & 32'hFFFFF000; wr = 1'b1; end
            7'h17: begin e.in1 = pc; e.in2 = ins & 32'hFFFFF000; wr = 1'b1; end
            7'h03: begin e.in1 = a; e.in2 = 32'($signed(ins[31:20])); e.ld = 1'b1; wr = 1'b1; end
            7'h23: begin e.in1 = a; e.in2 = 32'($signed(simm)); e.st = b; e.sto = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end else if (wr && rd != 5'd0) begin
            e.we = 1'b1;
            e.rd = rd;
        end
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic bit model_hazard(input logic [31:0] ins);
        return q.valid && q.ld && q.rd != 5'd0 &&
               ((rs1_used(ins[6:0]) && q.rd == ins[19:15]) || (rs2_used(ins[6:0]) && q.rd == ins[24:20]));
    endfunction

    task automatic check_ps3(input string tag);
        chk({tag, ":valid"},   {31'b0, bus.valid_Ps3},      {31'b0, q.valid});
        chk({tag, ":we"},      {31'b0, bus.Ctrl_rf_we_Ps3}, {31'b0, q.we});
        chk({tag, ":load"},    {31'b0, bus.Ctrl_load_Ps3},  {31'b0, q.ld});
        chk({tag, ":store"},   {31'b0, bus.Ctrl_store_Ps3}, {31'b0, q.sto});
        chk({tag, ":illegal"}, {31'b0, bus.illegal_Ps3},    {31'b0, q.ill});
        if (!q.ill) begin
            chk({tag, ":in1"},   bus.Data_in1_Ps3,   q.in1);
            chk({tag, ":in2"},   bus.Data_in2_Ps3,   q.in2);
            chk({tag, ":st"},    bus.Data_store_Ps3, q.st);
            chk({tag, ":alu"},   {29'b0, bus.Ctrl_ALU_Ps3},   {29'b0, q.alu});
            chk({tag, ":func7"}, {25'b0, bus.Ctrl_func7_Ps3}, {25'b0, q.f7});
            chk({tag, ":rd"},    {27'b0, bus.Ctrl_rd_Ps3},    {27'b0, q.rd});
        end
    endtask

    // Called at a negedge: drive, check comb outputs, clock once, check Ps3; ends at next negedge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic v, input logic s, input logic f,
                        input string tag);
        exp_t nq;
        bit   hz;
        bus.instr_Ps2    = ins;
        bus.pc_Ps2       = pc;
        bus.rs1_data_Ps2 = a;
        bus.rs2_data_Ps2 = b;
        bus.valid_Ps2    = v;
        bus.stall_in     = s;
        bus.flush        = f;
        #1;
        hz = model_hazard(ins);
        chk({tag, ":ready"}, {31'b0, bus.ready_Ps2}, {31'b0, (!s && !hz)});
        chk({tag, ":rs1a"},  {27'b0, bus.rs1_addr_Ps2}, 32'(ins[19:15]));
        chk({tag, ":rs2a"},  {27'b0, bus.rs2_addr_Ps2}, 32'(ins[24:20]));
        if (f)               nq = '0;
        else if (s)          nq = q;
        else if (hz || !v)   nq = '0;
        else                 nq = predict(ins, pc, a, b);
        @(posedge clk);
        q = nq;
        #1;
        check_ps3(tag);
        @(negedge clk);
    endtask

    logic [6:0] opt [6];
    logic [31:0] rins;

    initial begin
        opt = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
        q   = '0;
        bus.valid_Ps2 = 1'b0; bus.instr_Ps2 = '0; bus.pc_Ps2 = '0;
        bus.rs1_data_Ps2 = '0; bus.rs2_data_Ps2 = '0; bus.stall_in = 1'b0; bus.flush = 1'b0;
        #1;
        check_ps3("reset");
        chk("reset:ready", {31'b0, bus.ready_Ps2}, 32'd1);
        #2 rstn = 1'b1;
        @(negedge clk);

        step(32'hFFB00093, 32'h100, 32'd0, 32'h55, 1'b1, 1'b0, 1'b0, "addi");
        chk("addi:in2_const", bus.Data_in2_Ps3, 32'hFFFFFFFB);
        chk("addi:rd_const",  {27'b0, bus.Ctrl_rd_Ps3}, 32'd1);
        step(32'h402081B3, 32'h104, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0, "sub");
        chk("sub:func7_const", {25'b0, bus.Ctrl_func7_Ps3}, 32'h20);
        step(32'h40435293, 32'h108, 32'h8000_0000, 32'd7, 1'b1, 1'b0, 1'b0, "srai");
        chk("srai:in2_const", bus.Data_in2_Ps3, 32'd4);
        chk("srai:alu_const", {29'b0, bus.Ctrl_ALU_Ps3}, 32'd5);

        step(32'h00012083, 32'h10C, 32'h200, 32'd0, 1'b1, 1'b0, 1'b0, "lw");
        step(32'h001081B3, 32'h110, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, "lu_bubble");
        chk("lu_bubble:valid_const", {31'b0, bus.valid_Ps3}, 32'd0);
        step(32'h001081B3, 32'h110, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, "lu_add");
        chk("lu_add:rd_const", {27'b0, bus.Ctrl_rd_Ps3}, 32'd3);

        for (int i = 0; i < 3; i++)
            step(32'h00500113, 32'h114, 32'd77, 32'd0, 1'b1, 1'b1, 1'b0, $sformatf("stall%0d", i));
        chk("stall:rd_const", {27'b0, bus.Ctrl_rd_Ps3}, 32'd3);
        step(32'h00500113, 32'h114, 32'd77, 32'd0, 1'b1, 1'b1, 1'b1, "flush_stall");
        chk("flush_stall:valid_const", {31'b0, bus.valid_Ps3}, 32'd0);

        step(32'h00012083, 32'h118, 32'h300, 32'd0, 1'b1, 1'b0, 1'b0, "lw2");
        step(32'h001081B3, 32'h11C, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, "flush_hazard");

        step(32'h0000006F, 32'h120, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, "jal");
        chk("jal:illegal_const", {31'b0, bus.illegal_Ps3}, 32'd1);
        step(32'h00A00093, 32'h124, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "pre_rst");

        rstn = 1'b0;
        q    = '0;
        #1;
        check_ps3("async_rst");
        #1 rstn = 1'b1;
        step(32'h123450B7, 32'h128, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "post_rst_lui");

        for (int i = 0; i < 400; i++) begin
            int k;
            rins = $urandom;
            k = $urandom_range(0, 7);
            rins[11:7]  = 5'($urandom_range(0, 3));
            rins[19:15] = 5'($urandom_range(0, 3));
            rins[24:20] = 5'($urandom_range(0, 3));
            if (k < 6) rins[6:0] = opt[k];
            else if (k == 7) begin
                rins[6:0]   = 7'h13;
                rins[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
            end
            if ((k == 0 || k == 7) && $urandom_range(0, 3) != 0)
                rins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            step(rins, $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
